emergency_sequencer: RTL

Sequential controller that owns the emergency_control datapath.
- Generates its enable (emergency_control_valid_o) after a power-up settle period.
- Debounces the returned warning/alert levels.
- Latches water/gas shutoff actions until a user acknowledge.
- Sits between emergency_control and the valve/siren drivers of the home controller.

---
 rtl/emergency_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/emergency_sequencer.sv
// Emergency sequencer: settles after arming, debounces warning/alert levels and
// latches valve/siren actions until acknowledged. Optional macro: EMERGENCY_EVENT_COUNT_EN.
module emergency_sequencer #(
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       arm_i,
  input  logic       ack_i,
  input  logic       warning_i,
  input  logic       alert_i,
  output logic       emergency_control_valid_o,
  output logic       water_valve_close_o,
  output logic       gas_valve_close_o,
  output logic       buzzer_o,
  output logic       siren_o,
  output logic [2:0] state_o
`ifdef EMERGENCY_EVENT_COUNT_EN
 ,output logic [7:0] water_events_o,
  output logic [7:0] gas_events_o
`endif
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_DONE     = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    ST_DISARMED   = 3'd0,
    ST_SETTLE     = 3'd1,
    ST_MONITOR    = 3'd2,
    ST_WATER_DB   = 3'd3,
    ST_GAS_DB     = 3'd4,
    ST_WATER_LOCK = 3'd5,
    ST_GAS_LOCK   = 3'd6
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_water_flag;
`ifdef EMERGENCY_EVENT_COUNT_EN
  logic [7:0]       r_water_events;
  logic [7:0]       r_gas_events;
`endif

  // A debounce state locks on the edge after its counter reaches DB_DONE, so the
  // lock appears DEBOUNCE_CYCLES+1 edges after the first high sample in MONITOR.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= ST_DISARMED;
      r_cnt        <= '0;
      r_water_flag <= 1'b0;
`ifdef EMERGENCY_EVENT_COUNT_EN
      r_water_events <= '0;
      r_gas_events   <= '0;
`endif
    end else begin
      case (r_state)
        ST_DISARMED: begin
          if (arm_i) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (!arm_i)                   r_state <= ST_DISARMED;
          else if (r_cnt == SETTLE_LAST) r_state <= ST_MONITOR;
          else                          r_cnt   <= r_cnt + CNT_W'(1);
        end
        ST_MONITOR: begin
          if (!arm_i) begin
            r_state <= ST_DISARMED;
          end else if (alert_i) begin
            r_state <= ST_GAS_DB;
            r_cnt   <= '0;
          end else if (warning_i) begin
            r_state <= ST_WATER_DB;
            r_cnt   <= '0;
          end
        end
        ST_WATER_DB: begin
          if (!arm_i) begin
            r_state <= ST_DISARMED;
          end else if (alert_i) begin
            r_state <= ST_GAS_DB;
            r_cnt   <= '0;
          end else if (r_cnt == DB_DONE) begin
            r_state      <= ST_WATER_LOCK;
            r_water_flag <= 1'b1;
`ifdef EMERGENCY_EVENT_COUNT_EN
            if (r_water_events != 8'hFF) r_water_events <= r_water_events + 8'd1;
`endif
          end else if (warning_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_state <= ST_MONITOR;
          end
        end
        ST_GAS_DB: begin
          if (!arm_i) begin
            r_state <= ST_DISARMED;
          end else if (r_cnt == DB_DONE) begin
            r_state <= ST_GAS_LOCK;
`ifdef EMERGENCY_EVENT_COUNT_EN
            if (r_gas_events != 8'hFF) r_gas_events <= r_gas_events + 8'd1;
`endif
          end else if (alert_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_state <= ST_MONITOR;
          end
        end
        ST_WATER_LOCK: begin
          if (alert_i) begin
            r_state <= ST_GAS_DB;
            r_cnt   <= '0;
          end else if (ack_i) begin
            r_state      <= ST_MONITOR;
            r_water_flag <= 1'b0;
          end
        end
        ST_GAS_LOCK: begin
          if (ack_i) begin
            r_state      <= ST_SETTLE;
            r_cnt        <= '0;
            r_water_flag <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_DISARMED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign state_o                   = r_state;
  assign emergency_control_valid_o = (r_state == ST_MONITOR)  || (r_state == ST_WATER_DB) ||
                                     (r_state == ST_GAS_DB)   || (r_state == ST_WATER_LOCK);
  assign water_valve_close_o       = r_water_flag;
  assign gas_valve_close_o         = (r_state == ST_GAS_LOCK);
  assign siren_o                   = (r_state == ST_GAS_LOCK);
  assign buzzer_o                  = (r_state == ST_WATER_LOCK);
`ifdef EMERGENCY_EVENT_COUNT_EN
  assign water_events_o            = r_water_events;
  assign gas_events_o              = r_gas_events;
`endif

endmodule
